// File: rtl/fetch_predict_if.sv
// Bundle between the fetch stage and the rest of the pipeline. Carries ID/EX branch
// information in, and instruction-memory addressing, prediction and perf counters out.
interface fetch_predict_if #(
    parameter int XLEN      = 32,
    parameter int CNT_WIDTH = 16
);
    logic                 ID_branch;
    logic                 ID_unconditional_jmp;
    logic [XLEN-1:0]      ID_imme;
    logic                 EX_branch;
    logic                 EX_unconditional_jmp;
    logic                 EX_zero;
    logic                 EX_stall;
    logic [XLEN-1:0]      inst_mem_read_addr;
    logic                 inst_mem_read_enable;
    logic                 IF_take;
    logic                 IF_flush;
    logic [CNT_WIDTH-1:0] perf_branch_count;
    logic [CNT_WIDTH-1:0] perf_mispredict_count;

    modport master (
        input  ID_branch, ID_unconditional_jmp, ID_imme,
        input  EX_branch, EX_unconditional_jmp, EX_zero, EX_stall,
        output inst_mem_read_addr, inst_mem_read_enable, IF_take, IF_flush,
        output perf_branch_count, perf_mispredict_count
    );

    modport slave (
        output ID_branch, ID_unconditional_jmp, ID_imme,
        output EX_branch, EX_unconditional_jmp, EX_zero, EX_stall,
        input  inst_mem_read_addr, inst_mem_read_enable, IF_take, IF_flush,
        input  perf_branch_count, perf_mispredict_count
    );
endinterface

// File: rtl/fetch_predict.sv
// Instruction-fetch stage: owns the PC, predicts ID branches from a tagged direct-mapped
// table of 2-bit counters, trains/redirects on EX resolution and counts branches.
module fetch_predict #(
    parameter int              XLEN         = 32,
    parameter int              BHT_IDX_BITS = 6,
    parameter bit              DEFAULT_TAKE = 1'b1,
    parameter logic [XLEN-1:0] RESET_PC     = '0,
    parameter int              CNT_WIDTH    = 16
) (
    input logic              clk,
    input logic              reset,
    fetch_predict_if.master  bus
);
    localparam int ENTRIES = 1 << BHT_IDX_BITS;
    localparam int TAG_W   = XLEN - BHT_IDX_BITS - 2;

    typedef logic [BHT_IDX_BITS-1:0] idx_t;
    typedef logic [TAG_W-1:0]        tag_t;

    logic [XLEN-1:0]      pc_q, pc_d, base_q, base_d, imme_q, imme_d;
    logic                 pred_q, pred_d;
    logic [ENTRIES-1:0]   valid_q, valid_d;
    tag_t                 tag_q [ENTRIES];
    logic [1:0]           ctr_q [ENTRIES];
    logic [CNT_WIDTH-1:0] br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;

    logic [XLEN-1:0] pc_jmp;
    idx_t            lk_idx, tr_idx;
    tag_t            lk_tag, tr_tag;
    logic            lk_hit, lk_pred, tr_hit;
    logic            res, mis;
    logic [1:0]      ctr_wdata;

    // Lookup for the branch now in ID (fetched one slot before the current pc).
    assign pc_jmp  = pc_q - XLEN'(4);
    assign lk_idx  = pc_jmp[BHT_IDX_BITS+1:2];
    assign lk_tag  = pc_jmp[XLEN-1:BHT_IDX_BITS+2];
    assign lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_pred = lk_hit ? ctr_q[lk_idx][1] : DEFAULT_TAKE;

    assign tr_idx  = base_q[BHT_IDX_BITS+1:2];
    assign tr_tag  = base_q[XLEN-1:BHT_IDX_BITS+2];
    assign tr_hit  = valid_q[tr_idx] && (tag_q[tr_idx] == tr_tag);

    assign res = bus.EX_branch && !bus.EX_unconditional_jmp && !bus.EX_stall;
    assign mis = res && (pred_q != bus.EX_zero);

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        valid_d   = valid_q;
        ctr_wdata = bus.EX_zero ? 2'b10 : 2'b01;
        if (tr_hit) begin
            if (bus.EX_zero) ctr_wdata = (ctr_q[tr_idx] == 2'b11) ? 2'b11 : ctr_q[tr_idx] + 2'd1;
            else             ctr_wdata = (ctr_q[tr_idx] == 2'b00) ? 2'b00 : ctr_q[tr_idx] - 2'd1;
        end
        if (res) valid_d[tr_idx] = 1'b1;

        br_cnt_d  = (res && br_cnt_q  != '1) ? br_cnt_q  + CNT_WIDTH'(1) : br_cnt_q;
        mis_cnt_d = (mis && mis_cnt_q != '1) ? mis_cnt_q + CNT_WIDTH'(1) : mis_cnt_q;
    end

    // Redirect priority: stall, EX mispredict, ID conditional, ID jump, sequential.
    always_comb begin
        pc_d   = pc_q;
        base_d = base_q;
        imme_d = imme_q;
        pred_d = pred_q;
        if (!bus.EX_stall) begin
            if (mis) begin
                pc_d = pred_q ? base_q + XLEN'(4) : base_q + imme_q;
            end else if (bus.ID_branch && !bus.ID_unconditional_jmp) begin
                pc_d   = lk_pred ? pc_jmp + bus.ID_imme : pc_jmp + XLEN'(4);
                base_d = pc_jmp;
                imme_d = bus.ID_imme;
                pred_d = lk_pred;
            end else if (bus.ID_unconditional_jmp) begin
                pc_d = pc_q + bus.ID_imme;
            end else begin
                pc_d = pc_q + XLEN'(4);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignment so all flops sample pre-edge values.
        if (reset) begin
            pc_q      <= RESET_PC;
            base_q    <= '0;
            imme_q    <= '0;
            pred_q    <= 1'b0;
            valid_q   <= '0;
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            pc_q      <= pc_d;
            base_q    <= base_d;
            imme_q    <= imme_d;
            pred_q    <= pred_d;
            valid_q   <= valid_d;
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    // NOTE: tag/counter storage is deliberately not reset; valid_q alone qualifies every read.
    always_ff @(posedge clk) begin
        if (res) begin
            tag_q[tr_idx] <= tr_tag;
            ctr_q[tr_idx] <= ctr_wdata;
        end
    end

    assign bus.inst_mem_read_addr    = pc_q;
    assign bus.inst_mem_read_enable  = 1'b1;
    assign bus.IF_take               = pred_q;
    assign bus.IF_flush              = mis;
    assign bus.perf_branch_count     = br_cnt_q;
    assign bus.perf_mispredict_count = mis_cnt_q;
endmodule

// File: tb/tb_fetch_predict.sv
// Self-checking bench for fetch_predict: directed test-plan scenarios plus randomized
// traffic, all compared against an abstract reference model of the fetch/predict rules.
module tb_fetch_predict;
    localparam int XLEN     = 32;
    localparam int IDXB     = 6;
    localparam int CNT_W    = 10;
    localparam bit DEF_TAKE = 1'b1;
    localparam int CMAX     = (1 << CNT_W) - 1;
    localparam int NENT     = 1 << IDXB;

    typedef struct {
        bit              idb, idu;
        logic [XLEN-1:0] imm;
        bit              exb, exu, exz, stall;
    } stim_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fetch_predict_if #(.XLEN(XLEN), .CNT_WIDTH(CNT_W)) bus ();

    fetch_predict #(
        .XLEN(XLEN), .BHT_IDX_BITS(IDXB), .DEFAULT_TAKE(DEF_TAKE),
        .RESET_PC(32'h0), .CNT_WIDTH(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus.master)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model: architectural pc, one-entry stash, table of counters as plain ints.
    logic [XLEN-1:0] m_pc, m_base, m_imme;
    bit              m_pred;
    bit              m_valid [NENT];
    logic [XLEN-1:0] m_tag   [NENT];
    int              m_ctr   [NENT];
    int              m_br, m_mis;

    function automatic int idx_of(input logic [XLEN-1:0] a);
        return int'((a / 4) % NENT);
    endfunction

    function automatic logic [XLEN-1:0] tag_of(input logic [XLEN-1:0] a);
        return a / (4 * NENT);
    endfunction

    function automatic bit model_predict();
        logic [XLEN-1:0] pcj;
        int i;
        pcj = m_pc - 4;
        i   = idx_of(pcj);
        if (m_valid[i] && m_tag[i] == tag_of(pcj)) return m_ctr[i] >= 2;
        return DEF_TAKE;
    endfunction

    function automatic void model_reset();
        m_pc = 0; m_base = 0; m_imme = 0; m_pred = 0;
        m_br = 0; m_mis = 0;
        foreach (m_valid[i]) m_valid[i] = 0;
    endfunction

    function automatic void model_step(input stim_t s);
        bit res, mis, p;
        logic [XLEN-1:0] pcj;
        int i;
        if (s.stall) return;
        res = s.exb && !s.exu;
        mis = res && (m_pred != s.exz);
        p   = model_predict();
        pcj = m_pc - 4;
        if (res) begin
            i = idx_of(m_base);
            if (m_valid[i] && m_tag[i] == tag_of(m_base)) begin
                if (s.exz) m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                else       m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end else begin
                m_valid[i] = 1;
                m_tag[i]   = tag_of(m_base);
                m_ctr[i]   = s.exz ? 2 : 1;
            end
            if (m_br < CMAX) m_br++;
            if (mis && m_mis < CMAX) m_mis++;
        end
        if (mis) begin
            m_pc = m_pred ? m_base + 4 : m_base + m_imme;
        end else if (s.idb && !s.idu) begin
            m_pc   = p ? pcj + s.imm : pcj + 4;
            m_base = pcj;
            m_imme = s.imm;
            m_pred = p;
        end else if (s.idu) begin
            m_pc = m_pc + s.imm;
        end else begin
            m_pc = m_pc + 4;
        end
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.idb = 0; s.idu = 0; s.imm = 0;
        s.exb = 0; s.exu = 0; s.exz = 0; s.stall = 0;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        bus.ID_branch            = s.idb;
        bus.ID_unconditional_jmp = s.idu;
        bus.ID_imme              = s.imm;
        bus.EX_branch            = s.exb;
        bus.EX_unconditional_jmp = s.exu;
        bus.EX_zero              = s.exz;
        bus.EX_stall             = s.stall;
    endtask

    task automatic check_regs(input string tag);
        check({tag, "/addr"},  bus.inst_mem_read_addr, m_pc);
        check({tag, "/take"},  bus.IF_take, m_pred);
        check({tag, "/brcnt"}, bus.perf_branch_count, m_br);
        check({tag, "/miscnt"}, bus.perf_mispredict_count, m_mis);
    endtask

    // Called at a negedge; drives, checks comb flush, clocks the model, checks registers.
    task automatic cycle(input stim_t s, input string tag);
        bit exp_flush;
        drive(s);
        #1;
        exp_flush = !s.stall && s.exb && !s.exu && (m_pred != s.exz);
        check({tag, "/flush"}, bus.IF_flush, exp_flush);
        @(posedge clk);
        model_step(s);
        #1;
        check_regs(tag);
        @(negedge clk);
    endtask

    // Assert reset between edges so only an asynchronous reset clears state immediately.
    task automatic do_reset(input string tag);
        #2;
        drive(idle());
        reset = 1'b1;
        #1;
        model_reset();
        check({tag, "/en"}, bus.inst_mem_read_enable, 1'b1);
        check({tag, "/flush"}, bus.IF_flush, 1'b0);
        check_regs(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic go_to(input logic [XLEN-1:0] t);
        stim_t s = idle();
        s.idu = 1;
        s.imm = t - m_pc;
        cycle(s, "goto");
    endtask

    task automatic branch(input logic [XLEN-1:0] imm, input string tag);
        stim_t s = idle();
        s.idb = 1;
        s.imm = imm;
        cycle(s, tag);
    endtask

    task automatic resolve(input bit z, input string tag);
        stim_t s = idle();
        s.exb = 1;
        s.exz = z;
        cycle(s, tag);
    endtask

    function automatic logic [XLEN-1:0] rand_target();
        logic [XLEN-1:0] t;
        t = $urandom_range(0, 15) * 4;
        if ($urandom_range(0, 3) == 0) t = t + 32'h100;
        return t;
    endfunction

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        stim_t s;
        logic [XLEN-1:0] saved_pc;
        int saved_br, saved_mis;

        drive(idle());
        @(negedge clk);
        do_reset("reset");

        for (int k = 0; k < 4; k++) begin
            check("idle_addr", bus.inst_mem_read_addr, 32'(k * 4));
            cycle(idle(), "idle");
        end
        repeat (5) cycle(idle(), "idle");
        check("at_24", bus.inst_mem_read_addr, 32'h24);

        // Cold table: default-taken prediction, then a not-taken resolution.
        branch(32'h40, "cold_br");
        check("cold_pc", bus.inst_mem_read_addr, 32'h60);
        check("cold_take", bus.IF_take, 1'b1);
        resolve(1'b0, "cold_res");
        check("cold_redirect", bus.inst_mem_read_addr, 32'h24);
        check("cold_miscnt", bus.perf_mispredict_count, 1);

        // Aliasing branch at 0x120 misses; its allocation evicts the 0x20 entry.
        go_to(32'h124);
        branch(32'h40, "alias_br");
        check("alias_take", bus.IF_take, 1'b1);
        resolve(1'b0, "alias_res");
        go_to(32'h24);
        branch(32'h40, "evicted_br");
        check("evicted_take", bus.IF_take, 1'b1);
        resolve(1'b1, "evicted_res");

        // Train toward strong-taken, then one not-taken must not flip the prediction.
        repeat (2) begin
            go_to(32'h24);
            branch(32'h40, "train_br");
            check("train_take", bus.IF_take, 1'b1);
            resolve(1'b1, "train_res");
        end
        go_to(32'h24);
        branch(32'h40, "sat_br");
        resolve(1'b0, "sat_res");
        check("sat_pc", bus.inst_mem_read_addr, 32'h24);
        branch(32'h40, "sat_br2");
        check("sat_take", bus.IF_take, 1'b1);
        resolve(1'b1, "sat_res2");

        // Stall during a resolving mispredict freezes everything until release.
        go_to(32'h24);
        branch(32'h40, "stall_br");
        saved_pc  = bus.inst_mem_read_addr;
        saved_br  = m_br;
        saved_mis = m_mis;
        s = idle();
        s.exb = 1; s.exz = 0; s.stall = 1; s.idb = 1; s.imm = 32'h8;
        repeat (3) begin
            cycle(s, "stall");
            check("stall_pc", bus.inst_mem_read_addr, saved_pc);
            check("stall_brcnt", bus.perf_branch_count, saved_br);
        end
        resolve(1'b0, "stall_rel");
        check("stall_rel_br", bus.perf_branch_count, saved_br + 1);
        check("stall_rel_mis", bus.perf_mispredict_count, saved_mis + 1);
        check("stall_rel_pc", bus.inst_mem_read_addr, 32'h24);

        // Correct EX prediction coinciding with a new ID branch.
        branch(32'h40, "corr_br");
        saved_br  = m_br;
        saved_mis = m_mis;
        s = idle();
        s.exb = 1; s.exz = m_pred; s.idb = 1; s.imm = 32'h80;
        cycle(s, "corr_id");
        check("corr_br_cnt", bus.perf_branch_count, saved_br + 1);
        check("corr_mis_cnt", bus.perf_mispredict_count, saved_mis);

        // Randomized traffic kept near a small address window so table entries get reused.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset("rnd_reset");
            end else begin
                s = idle();
                s.stall = ($urandom_range(0, 9) == 0);
                s.exb   = ($urandom_range(0, 9) < 4);
                s.exu   = s.exb && ($urandom_range(0, 4) == 0);
                s.exz   = $urandom_range(0, 1);
                s.idb   = ($urandom_range(0, 9) < 4);
                s.idu   = ($urandom_range(0, 3) == 0);
                if (s.idu)      s.imm = rand_target() - m_pc;
                else            s.imm = rand_target() - (m_pc - 4);
                if ($urandom_range(0, 19) == 0) s.imm = $urandom;
                cycle(s, "rnd");
            end
        end

        // Counter saturation: every cycle resolves as a mispredict.
        do_reset("sat_reset");
        for (int n = 0; n < CMAX + 2; n++) begin
            s = idle();
            s.exb = 1;
            s.exz = !m_pred;
            cycle(s, "cnt_sat");
        end
        check("sat_br_all1", bus.perf_branch_count, CMAX);
        check("sat_mis_all1", bus.perf_mispredict_count, CMAX);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_predict.md
# fetch_predict

Parametrised instruction-fetch stage with a tagged, direct-mapped branch history table (BHT) of 2-bit saturating counters. It owns the PC and drives instruction-memory addressing. Conditional branches decoded in ID are predicted from the table and resolved in EX, where the table is trained and mispredictions are redirected. It sits at the head of the pipeline, feeding IF/ID, and adds performance counters for branches and mispredictions.

## Interface

- XLEN, 32: PC and immediate width.
- BHT_IDX_BITS, 6: table index width; 2^BHT_IDX_BITS entries, index = pc[BHT_IDX_BITS+1:2], tag = pc[XLEN-1:BHT_IDX_BITS+2].
- DEFAULT_TAKE, 1: prediction on a table miss (1 = taken).
- RESET_PC, 0: PC value after reset.
- CNT_WIDTH, 16: performance counter width.

- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ID_branch  in  1  ID holds a branch or jump.
- ID_unconditional_jmp  in  1  ID holds an unconditional jump.
- ID_imme  in  XLEN  branch/jump offset from ID.
- EX_branch  in  1  EX holds a branch or jump.
- EX_unconditional_jmp  in  1  EX branch is unconditional.
- EX_zero  in  1  resolved condition; 1 = taken.
- EX_stall  in  1  load-use stall; freezes all state.
- inst_mem_read_addr  out  XLEN  equals pc.
- inst_mem_read_enable  out  1  constant 1.
- IF_take  out  1  predicted direction of the outstanding conditional branch (registered).
- IF_flush  out  1  combinational; high in a cycle whose edge applies a misprediction redirect.
- perf_branch_count  out  CNT_WIDTH  resolved conditional branches.
- perf_mispredict_count  out  CNT_WIDTH  mispredicted conditional branches.

## Operation

- State: pc; a single-entry stash of base (branch pc), imme and pred (predicted direction); BHT arrays valid, tag and ctr[1:0]; the two counters.
- Branch pc seen in ID is pc_jmp = pc − 4.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Predict taken = ctr[1].
- Lookup on pc_jmp. A hit is valid[idx] && tag[idx] == pc_jmp tag. On a hit, predict ctr[1]. On a miss, predict DEFAULT_TAKE.
- Resolution (res) = EX_branch && !EX_unconditional_jmp && !EX_stall. Mispredict (mis) = res && (pred != EX_zero).
- Next-pc priority on each edge:
  1. EX_stall: everything holds.
  2. mis: pc ← pred ? base+4 : base+imme. Any same-cycle ID branch or jump is discarded.
  3. ID_branch && !ID_unconditional_jmp: pc ← prediction ? pc_jmp+ID_imme : pc_jmp+4. Stash ← {pc_jmp, ID_imme, prediction}.
  4. ID_unconditional_jmp: pc ← pc + ID_imme.
  5. Otherwise: pc ← pc + 4.
- A correct prediction in EX does not block a same-cycle ID branch. Rule 3 applies, and the stash is overwritten after its use.
- Training on res, indexed by base:
  - Hit: ctr saturating +1 if EX_zero, −1 otherwise (11 stays 11, 00 stays 00).
  - Miss: allocate. Set valid ← 1 and tag ← base tag. Set ctr ← EX_zero ? 10 : 01.
- Same-cycle lookup and training at the same index: the lookup sees pre-update contents.
- Counters: on res, perf_branch_count +1. On mis, perf_mispredict_count +1. Both saturate at all-ones.
- Arithmetic is modulo 2^XLEN with wrap-around and no fault.

## Timing

- Reset (async, immediate):
  - pc = RESET_PC.
  - IF_take = 0, stash = 0.
  - All valid = 0; tags and counters are don't-care.
  - Both perf counters = 0.
  - IF_flush = 0 because stash pred = 0 and EX inputs are gated.
- inst_mem_read_addr follows pc with zero latency. Redirects take effect at the edge after the ID or EX condition.
- Predicted-taken branch costs 1 bubble (pc+4 of the branch already fetched). Mispredict costs 2 bubbles.
- IF_take updates on the same edge as the stash.
- Reset asserted mid-operation discards the outstanding branch with no training and no count.
- EX_stall held N cycles freezes pc, stash, BHT and counters for N cycles. IF_flush = 0 while stalled.

## Test plan

- Reset, then 4 idle cycles → addr 0, 4, 8, 12; IF_take = 0; both counters 0.
- ID_branch at pc = 0x24 (pc_jmp = 0x20), imme = 0x40, cold table with DEFAULT_TAKE = 1 → pc = 0x60, IF_take = 1. Next cycle, EX resolves EX_zero = 0 → IF_flush = 1, pc = 0x24, mispredict = 1, entry[8] = {valid, ctr = 01}.
- Same branch at 0x20 encountered again → predicted not-taken, pc = 0x24. Resolved taken → pc = 0x60, ctr = 10. Resolved taken twice more → ctr saturates at 11.
- Aliasing: branch at 0x20, then branch at 0x120 (same index, BHT_IDX_BITS = 6) → miss, DEFAULT_TAKE used. On resolution the tag is replaced.
- Hold EX_stall during a resolving EX branch for 3 cycles → pc, ctr and counters unchanged. Release → the single resolution is applied once.
- Correct prediction in EX coinciding with a new ID_branch → pc follows the ID prediction, stash holds the new branch, branch count +1, mispredict count unchanged. Also force 2^CNT_WIDTH+1 resolutions → counter stays at all-ones.
